// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls-and-Cows engine: state encoding,
// BCD digit type, 7-segment patterns and small decode helpers.
package bc_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_BULLS,
        ST_COWS,
        ST_WIN,
        ST_LOSE
    } state_t;

    typedef logic [3:0] digit_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input digit_t d);
        case (d)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic sw_is_onehot(input logic [9:0] sw);
        int n;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (sw[k]) n++;
        end
        sw_is_onehot = (n == 1);
    endfunction

    function automatic digit_t sw_to_digit(input logic [9:0] sw);
        sw_to_digit = '0;
        for (int k = 0; k < 10; k++) begin
            if (sw[k]) sw_to_digit = digit_t'(k);
        end
    endfunction

endpackage

// File: rtl/bc_btn_cond.sv
// Raw active-low button -> one-cycle press pulse; 3 cycles latency (+DEBOUNCE_CYCLES with BC_DEBOUNCE_EN).
// No backpressure: presses that occur while the engine is busy are simply dropped downstream.
module bc_btn_cond #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync_q1;
    logic sync_q2;
    logic lvl;
    logic lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
        end
    end

`ifdef BC_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CNT_W-1:0] stable_cnt;

    // A new level is adopted only after it has been seen DEBOUNCE_CYCLES times in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl        <= 1'b1;
            stable_cnt <= '0;
        end else if (sync_q2 == lvl) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            lvl        <= sync_q2;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end
`else
    assign lvl = sync_q2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_d <= 1'b1;
            press <= 1'b0;
        end else begin
            lvl_d <= lvl;
            press <= lvl_d & ~lvl;
        end
    end

endmodule

// File: rtl/bulls_cows_engine.sv
// Bulls-and-Cows game engine; scoring result 2*DIGITS+1 cycles after the enter event (debounce via BC_DEBOUNCE_EN).
// No backpressure: button events outside ENTRY are ignored; ans_load always wins and aborts scoring.
module bulls_cows_engine
    import bc_pkg::*;
#(
    parameter int          DIGITS          = 4,
    parameter int          MAX_GUESSES     = 8,
    parameter logic [31:0] RESET_ANSWER    = 32'h9527,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               btn_enter_n,
    input  logic                               btn_next_n,
    input  logic                               mode_sw,
    input  logic [9:0]                         digit_sw,
    input  logic                               ans_load,
    input  logic [4*DIGITS-1:0]                ans_value,
    output logic [4*DIGITS-1:0]                guess,
    output logic [DIGITS-1:0]                  cursor,
    output logic [7*DIGITS-1:0]                hex_n,
    output logic [$clog2(DIGITS+1)-1:0]        a_cnt,
    output logic [$clog2(DIGITS+1)-1:0]        b_cnt,
    output logic                               score_valid,
    output logic                               busy,
    output logic                               win,
    output logic                               lose,
    output logic [$clog2(MAX_GUESSES+1)-1:0]   guess_cnt,
    output logic                               entry_err
);

    localparam int CW = $clog2(DIGITS + 1);
    localparam int GW = $clog2(MAX_GUESSES + 1);
    localparam int JW = $clog2(DIGITS);

    logic enter_ev;
    logic next_ev;

    bc_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_enter_n),
        .press (enter_ev)
    );

    bc_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_next_n),
        .press (next_ev)
    );

    state_t                    state;
    logic [DIGITS-1:0][3:0]    guess_r;
    logic [DIGITS-1:0][3:0]    ans_r;
    logic [DIGITS-1:0]         used_r;
    logic [DIGITS-1:0]         done_r;
    logic [JW-1:0]             j_r;
    logic [CW-1:0]             a_acc;
    logic [CW-1:0]             b_acc;

    logic                      bull_hit;
    logic                      cow_hit;
    logic [DIGITS-1:0]         cow_sel;
    logic                      j_last;
    logic                      sw_ok;
    digit_t                    sw_digit;
    logic [CW-1:0]             b_next;
    logic [GW-1:0]             gcnt_next;

    assign guess     = guess_r;
    assign bull_hit  = (guess_r[j_r] == ans_r[j_r]);
    assign j_last    = (j_r == JW'(DIGITS - 1));
    assign sw_ok     = sw_is_onehot(digit_sw);
    assign sw_digit  = sw_to_digit(digit_sw);
    assign b_next    = b_acc + CW'(cow_hit);
    assign gcnt_next = guess_cnt + GW'(1);

    // Lowest unused guess position matching answer digit j; descending scan so the lowest match wins
    always_comb begin
        cow_hit = 1'b0;
        cow_sel = '0;
        if (!done_r[j_r]) begin
            for (int k = DIGITS - 1; k >= 0; k--) begin
                if (!used_r[k] && (guess_r[k] == ans_r[j_r])) begin
                    cow_hit    = 1'b1;
                    cow_sel    = '0;
                    cow_sel[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hex_n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            hex_n[7*i +: 7] = seg_decode(guess_r[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ENTRY;
            guess_r     <= '0;
            ans_r       <= RESET_ANSWER[4*DIGITS-1:0];
            cursor      <= DIGITS'(1);
            used_r      <= '0;
            done_r      <= '0;
            j_r         <= '0;
            a_acc       <= '0;
            b_acc       <= '0;
            a_cnt       <= '0;
            b_cnt       <= '0;
            score_valid <= 1'b0;
            busy        <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
            guess_cnt   <= '0;
            entry_err   <= 1'b0;
        end else begin
            entry_err <= 1'b0;
            if (ans_load) begin
                state       <= ST_ENTRY;
                ans_r       <= ans_value;
                guess_r     <= '0;
                cursor      <= DIGITS'(1);
                a_cnt       <= '0;
                b_cnt       <= '0;
                score_valid <= 1'b0;
                busy        <= 1'b0;
                win         <= 1'b0;
                lose        <= 1'b0;
                guess_cnt   <= '0;
            end else begin
                case (state)
                    ST_ENTRY: begin
                        if (mode_sw) begin
                            if (enter_ev) begin
                                if (sw_ok) begin
                                    for (int i = 0; i < DIGITS; i++) begin
                                        if (cursor[i]) guess_r[i] <= sw_digit;
                                    end
                                    score_valid <= 1'b0;
                                end else begin
                                    entry_err <= 1'b1;
                                end
                            end
                            if (next_ev) cursor <= {cursor[DIGITS-2:0], cursor[DIGITS-1]};
                        end else if (enter_ev) begin
                            score_valid <= 1'b0;
                            used_r      <= '0;
                            done_r      <= '0;
                            a_acc       <= '0;
                            b_acc       <= '0;
                            j_r         <= '0;
                            busy        <= 1'b1;
                            state       <= ST_BULLS;
                        end
                    end
                    ST_BULLS: begin
                        if (bull_hit) begin
                            a_acc     <= a_acc + CW'(1);
                            used_r[j_r] <= 1'b1;
                            done_r[j_r] <= 1'b1;
                        end
                        if (j_last) begin
                            j_r   <= '0;
                            state <= ST_COWS;
                        end else begin
                            j_r <= j_r + JW'(1);
                        end
                    end
                    ST_COWS: begin
                        b_acc  <= b_next;
                        used_r <= used_r | cow_sel;
                        if (j_last) begin
                            a_cnt       <= a_acc;
                            b_cnt       <= b_next;
                            score_valid <= 1'b1;
                            guess_cnt   <= gcnt_next;
                            busy        <= 1'b0;
                            if (a_acc == CW'(DIGITS)) begin
                                win   <= 1'b1;
                                state <= ST_WIN;
                            end else if (gcnt_next == GW'(MAX_GUESSES)) begin
                                lose  <= 1'b1;
                                state <= ST_LOSE;
                            end else begin
                                state <= ST_ENTRY;
                            end
                        end else begin
                            j_r <= j_r + JW'(1);
                        end
                    end
                    ST_WIN:  win  <= 1'b1;
                    ST_LOSE: lose <= 1'b1;
                    default: state <= ST_ENTRY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Directed + randomized bench for bulls_cows_engine (DIGITS=4) with a count-based scoring model.
// A second instance with MAX_GUESSES=2 shares the inputs and is used for the lose checks.
module tb_bulls_cows_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_enter_n = 1'b1;
    logic        btn_next_n = 1'b1;
    logic        mode_sw = 1'b1;
    logic [9:0]  digit_sw = '0;
    logic        ans_load = 1'b0;
    logic [15:0] ans_value = '0;

    logic [15:0] guess, guess2;
    logic [3:0]  cursor, cursor2;
    logic [27:0] hex_n, hex_n2;
    logic [2:0]  a_cnt, b_cnt, a_cnt2, b_cnt2;
    logic        score_valid, busy, win, lose, entry_err;
    logic        score_valid2, busy2, win2, lose2, entry_err2;
    logic [3:0]  guess_cnt;
    logic [1:0]  guess_cnt2;

    bulls_cows_engine #(.DIGITS(4), .MAX_GUESSES(8)) dut (
        .clk(clk), .rst(rst), .btn_enter_n(btn_enter_n), .btn_next_n(btn_next_n),
        .mode_sw(mode_sw), .digit_sw(digit_sw), .ans_load(ans_load), .ans_value(ans_value),
        .guess(guess), .cursor(cursor), .hex_n(hex_n), .a_cnt(a_cnt), .b_cnt(b_cnt),
        .score_valid(score_valid), .busy(busy), .win(win), .lose(lose),
        .guess_cnt(guess_cnt), .entry_err(entry_err)
    );

    bulls_cows_engine #(.DIGITS(4), .MAX_GUESSES(2)) dut2 (
        .clk(clk), .rst(rst), .btn_enter_n(btn_enter_n), .btn_next_n(btn_next_n),
        .mode_sw(mode_sw), .digit_sw(digit_sw), .ans_load(ans_load), .ans_value(ans_value),
        .guess(guess2), .cursor(cursor2), .hex_n(hex_n2), .a_cnt(a_cnt2), .b_cnt(b_cnt2),
        .score_valid(score_valid2), .busy(busy2), .win(win2), .lose(lose2),
        .guess_cnt(guess_cnt2), .entry_err(entry_err2)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int err_pulses = 0;

    always @(posedge clk) if (entry_err === 1'b1) err_pulses <= err_pulses + 1;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Reference game state
    int mg [4];
    int mans [4];
    int mcur;
    int mgc1, mgc2;
    int ea, eb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_guess();
        return {4'(mg[3]), 4'(mg[2]), 4'(mg[1]), 4'(mg[0])};
    endfunction

    function automatic logic [27:0] exp_hex();
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = (mg[i] > 9) ? 7'h7f : seg_tab[mg[i]];
        return r;
    endfunction

    // Bulls are positional matches; cows are the multiset overlap of the remaining digits
    function automatic void model_score();
        int cg [10];
        int ca [10];
        for (int v = 0; v < 10; v++) begin cg[v] = 0; ca[v] = 0; end
        ea = 0; eb = 0;
        for (int i = 0; i < 4; i++) begin
            if (mg[i] == mans[i]) ea++;
            else begin cg[mg[i]]++; ca[mans[i]]++; end
        end
        for (int v = 0; v < 10; v++) eb += (cg[v] < ca[v]) ? cg[v] : ca[v];
    endfunction

    task automatic press(input bit do_enter, input bit do_next);
        @(posedge clk); #1;
        if (do_enter) btn_enter_n = 1'b0;
        if (do_next)  btn_next_n  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        btn_enter_n = 1'b1;
        btn_next_n  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic put_digit(input int pos, input int val);
        while (mcur != pos) begin
            press(1'b0, 1'b1);
            mcur = (mcur + 1) % 4;
        end
        digit_sw = 10'b1 << val;
        press(1'b1, 1'b0);
        mg[pos] = val;
    endtask

    task automatic enter_guess(input string tag, input int d3, input int d2, input int d1, input int d0);
        put_digit(3, d3);
        put_digit(2, d2);
        put_digit(1, d1);
        put_digit(0, d0);
        check({tag, "_guess"}, 32'(guess), 32'(exp_guess()));
        check({tag, "_hex"}, 32'(hex_n), 32'(exp_hex()));
        check({tag, "_cursor"}, 32'(cursor), 32'(4'b1 << mcur));
    endtask

    task automatic load_answer(input int d3, input int d2, input int d1, input int d0);
        mans[3] = d3; mans[2] = d2; mans[1] = d1; mans[0] = d0;
        @(posedge clk); #1;
        ans_value = {4'(d3), 4'(d2), 4'(d1), 4'(d0)};
        ans_load  = 1'b1;
        @(posedge clk); #1;
        ans_load = 1'b0;
        for (int i = 0; i < 4; i++) mg[i] = 0;
        mcur = 0; mgc1 = 0; mgc2 = 0;
    endtask

    // Drives the check-mode enter press and follows dut to the scoring result
    task automatic score_guess(input string tag);
        int busy_n;
        logic sv11;
        busy_n = 0;
        sv11 = 1'bx;
        mode_sw = 1'b0;
        @(posedge clk); #1;
        btn_enter_n = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 4) btn_enter_n = 1'b1;
            if (busy === 1'b1) busy_n++;
            if (n == 11) sv11 = score_valid;
        end
        model_score();
        mgc1++;
        check({tag, "_sv_early"}, 32'(sv11), 32'd0);
        check({tag, "_sv"}, 32'(score_valid), 32'd1);
        check({tag, "_busy_len"}, 32'(busy_n), 32'd8);
        check({tag, "_a"}, 32'(a_cnt), 32'(ea));
        check({tag, "_b"}, 32'(b_cnt), 32'(eb));
        check({tag, "_gcnt"}, 32'(guess_cnt), 32'(mgc1));
        check({tag, "_win"}, 32'(win), 32'(ea == 4));
        mode_sw = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mg[i] = 0;
        mans[3] = 9; mans[2] = 5; mans[1] = 2; mans[0] = 7;
        mcur = 0; mgc1 = 0; mgc2 = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_guess", 32'(guess), 32'h0);
        check("rst_cursor", 32'(cursor), 32'h1);
        check("rst_hex", 32'(hex_n), 32'(exp_hex()));
        check("rst_flags", 32'({score_valid, busy, win, lose, entry_err}), 32'h0);
        check("rst_ab", 32'({a_cnt, b_cnt}), 32'h0);
        check("rst_gcnt", 32'(guess_cnt), 32'h0);

        enter_guess("g9257", 9, 2, 5, 7);
        score_guess("s9257");
        mgc2++;
        enter_guess("g9999", 9, 9, 9, 9);
        score_guess("s9999");
        mgc2++;
        check("d2_lose_first", 32'(lose2), 32'd1);

        load_answer(9, 5, 2, 7);
        check("load_gcnt", 32'(guess_cnt), 32'h0);
        check("load_lose2", 32'(lose2), 32'h0);
        check("load_guess", 32'(guess), 32'h0);
        check("load_cursor", 32'(cursor), 32'h1);

        enter_guess("g1254", 1, 2, 5, 4);
        score_guess("s1254");
        check("d2_1254_ab", 32'({a_cnt2, b_cnt2}), 32'({3'd0, 3'd2}));
        enter_guess("g7259", 7, 2, 5, 9);
        score_guess("s7259");
        check("d2_7259_ab", 32'({a_cnt2, b_cnt2}), 32'({3'd0, 3'd4}));
        check("d2_lose", 32'(lose2), 32'd1);
        check("d2_gcnt", 32'(guess_cnt2), 32'd2);
        check("d1_nolose", 32'(lose), 32'd0);

        // Invalid digit switch: no write, one error pulse
        begin
            int pulses0;
            pulses0 = err_pulses;
            digit_sw = 10'b0000100100;
            press(1'b1, 1'b0);
            digit_sw = 10'b0;
            press(1'b1, 1'b0);
            check("err_guess", 32'(guess), 32'(exp_guess()));
            check("err_pulses", 32'(err_pulses - pulses0), 32'd2);
            check("err_sv_kept", 32'(score_valid), 32'd1);
        end

        // Enter and next together: write at the old cursor, then advance
        digit_sw = 10'b1 << 3;
        press(1'b1, 1'b1);
        mg[mcur] = 3;
        mcur = (mcur + 1) % 4;
        check("both_guess", 32'(guess), 32'(exp_guess()));
        check("both_cursor", 32'(cursor), 32'(4'b1 << mcur));
        check("both_sv_clr", 32'(score_valid), 32'd0);
        check("d2_lose_ignored", 32'(guess2), 32'h7259);

        // Random answers and guesses
        load_answer($urandom_range(9), $urandom_range(9), $urandom_range(9), $urandom_range(9));
        for (int r = 0; r < 4; r++) begin
            enter_guess("rnd", $urandom_range(9), $urandom_range(9), $urandom_range(9), $urandom_range(9));
            score_guess("rnd_score");
        end

        // Abort scoring with a new answer mid-COWS
        mode_sw = 1'b0;
        @(posedge clk); #1;
        btn_enter_n = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (n == 4) btn_enter_n = 1'b1;
        end
        check("abort_busy_before", 32'(busy), 32'd1);
        ans_value = 16'h1234;
        ans_load  = 1'b1;
        @(posedge clk); #1;
        ans_load = 1'b0;
        mode_sw  = 1'b1;
        mans[3] = 1; mans[2] = 2; mans[1] = 3; mans[0] = 4;
        for (int i = 0; i < 4; i++) mg[i] = 0;
        mcur = 0; mgc1 = 0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_gcnt", 32'(guess_cnt), 32'd0);
        check("abort_sv", 32'(score_valid), 32'd0);
        check("abort_guess", 32'(guess), 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_result", 32'({score_valid, guess_cnt}), 32'h0);

        enter_guess("g1234", 1, 2, 3, 4);
        score_guess("s1234");
        check("win_flag", 32'(win), 32'd1);

        // Terminal WIN: buttons ignored
        digit_sw = 10'b1 << 8;
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        check("win_guess_held", 32'(guess), 32'h1234);
        check("win_cursor_held", 32'(cursor), 32'(4'b1 << mcur));
        check("win_held", 32'({win, lose, busy}), 32'b100);
        check("win_gcnt_held", 32'(guess_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
